// File: rtl/imem_pkg.sv
// Shared constants and response payload type for the instruction-memory responder.
package imem_pkg;

  localparam int unsigned ADDR_W         = 32;
  localparam int unsigned D_SIZE         = 32;
  localparam int unsigned IMEM_DEPTH     = 256;
  localparam int unsigned IMEM_LATENCY   = 2;
  localparam int unsigned IMEM_RSP_DEPTH = 4;

  localparam int unsigned IMEM_IDX_W     = $clog2(IMEM_DEPTH);

  localparam logic [D_SIZE-1:0] IMEM_NOP = D_SIZE'(32'h0);

  typedef struct packed {
    logic              err;
    logic [D_SIZE-1:0] inst;
  } imem_rsp_t;

endpackage

// File: rtl/imem_if.sv
// Fetch-side request/response, program-load and flush signals of the instruction memory.
interface imem_if;
  import imem_pkg::*;

  logic              req_valid;
  logic              req_ready;
  logic [ADDR_W-1:0] req_addr;
  logic              rsp_valid;
  logic              rsp_ready;
  logic [D_SIZE-1:0] rsp_inst;
  logic              rsp_err;
  logic              load_en;
  logic [ADDR_W-1:0] load_addr;
  logic [D_SIZE-1:0] load_data;
  logic              flush;
  logic              busy;

  modport master (
    output req_valid, req_addr, rsp_ready, load_en, load_addr, load_data, flush,
    input  req_ready, rsp_valid, rsp_inst, rsp_err, busy
  );

  modport slave (
    input  req_valid, req_addr, rsp_ready, load_en, load_addr, load_data, flush,
    output req_ready, rsp_valid, rsp_inst, rsp_err, busy
  );

endinterface

// File: rtl/imem_rsp_fifo.sv
// Response buffer: N-entry synchronous FIFO of imem_rsp_t with wrap-bit pointers (N a power of 2).
module imem_rsp_fifo
  import imem_pkg::*;
#(
  parameter int unsigned N = IMEM_RSP_DEPTH
) (
  input  logic      clk,
  input  logic      reset,
  input  logic      clear,
  input  logic      push,
  input  imem_rsp_t push_data,
  input  logic      pop,
  output imem_rsp_t pop_data,
  output logic      full,
  output logic      empty
);

  localparam int unsigned PW = $clog2(N);

  logic [PW:0] wptr;
  logic [PW:0] rptr;
  imem_rsp_t   store [N];

  assign empty = (wptr == rptr);
  assign full  = (wptr[PW] != rptr[PW]) && (wptr[PW-1:0] == rptr[PW-1:0]);

  // Drive zeros while empty so the response bus is deterministic between transfers.
  assign pop_data = empty ? imem_rsp_t'('0) : store[rptr[PW-1:0]];

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wptr <= '0;
      rptr <= '0;
    end else if (clear) begin
      wptr <= '0;
      rptr <= '0;
    end else begin
      if (push && !full) wptr <= wptr + (PW+1)'(1);
      if (pop && !empty) rptr <= rptr + (PW+1)'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (push && !full) store[wptr[PW-1:0]] <= push_data;
  end

endmodule

// File: rtl/imem_responder.sv
// Memory-side end of the fetch interface: storage, fixed-latency read pipe, credit flow
// control and an in-order response buffer.
module imem_responder
  import imem_pkg::*;
#(
  parameter int unsigned DEPTH     = IMEM_DEPTH,
  parameter int unsigned LATENCY   = IMEM_LATENCY,
  parameter int unsigned RSP_DEPTH = IMEM_RSP_DEPTH
) (
  input  logic   clk,
  input  logic   reset,
  imem_if.slave  bus
);

  localparam int unsigned IDX_W  = $clog2(DEPTH);
  localparam int unsigned CNT_W  = $clog2(RSP_DEPTH + 1);
  localparam int unsigned PIPE_N = (LATENCY > 1) ? LATENCY - 1 : 1;
  localparam logic [CNT_W-1:0] CREDIT_MAX = CNT_W'(RSP_DEPTH);

  logic [D_SIZE-1:0] mem [DEPTH];

  logic [IDX_W-1:0]  req_idx;
  logic [IDX_W-1:0]  load_idx;
  logic              req_bad;
  logic              load_bad;
  logic              load_ok;
  logic              accept;
  logic              pop;
  logic [CNT_W-1:0]  credits;

  imem_rsp_t         rd_rsp;
  imem_rsp_t         push_rsp;
  imem_rsp_t         fifo_rsp;
  logic              push;
  logic              push_ok;
  logic              fifo_full;
  logic              fifo_empty;

  logic [PIPE_N-1:0] pipe_v;
  imem_rsp_t         pipe_d [PIPE_N];

  assign req_idx  = bus.req_addr[IDX_W+1:2];
  assign load_idx = bus.load_addr[IDX_W+1:2];
  assign req_bad  = (bus.req_addr[1:0] != 2'b00) || (bus.req_addr[ADDR_W-1:IDX_W+2] != '0);
  assign load_bad = (bus.load_addr[1:0] != 2'b00) || (bus.load_addr[ADDR_W-1:IDX_W+2] != '0);
  assign load_ok  = bus.load_en && !load_bad;

  assign bus.req_ready = (credits != '0) && !bus.flush;
  assign accept        = bus.req_valid && bus.req_ready;

  // Program-load port; storage is intentionally not reset.
  always_ff @(posedge clk) begin
    if (load_ok) mem[load_idx] <= bus.load_data;
  end

  // Read at acceptance; a same-cycle load to the same word is forwarded (write-first).
  always_comb begin
    rd_rsp.err  = req_bad;
    rd_rsp.inst = IMEM_NOP;
    if (!req_bad) begin
      rd_rsp.inst = (load_ok && (load_idx == req_idx)) ? bus.load_data : mem[req_idx];
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      pipe_v <= '0;
    end else if (bus.flush) begin
      pipe_v <= '0;
    end else begin
      pipe_v[0] <= accept;
      for (int i = 1; i < PIPE_N; i++) pipe_v[i] <= pipe_v[i-1];
    end
  end

  always_ff @(posedge clk) begin
    pipe_d[0] <= rd_rsp;
    for (int i = 1; i < PIPE_N; i++) pipe_d[i] <= pipe_d[i-1];
  end

  // The FIFO write is the final register stage, so LATENCY==1 pushes straight from the read.
  assign push     = (LATENCY == 1) ? accept : pipe_v[PIPE_N-1];
  assign push_rsp = (LATENCY == 1) ? rd_rsp : pipe_d[PIPE_N-1];
  assign push_ok  = push && !fifo_full;

  imem_rsp_fifo #(.N(RSP_DEPTH)) u_rsp_fifo (
    .clk       (clk),
    .reset     (reset),
    .clear     (bus.flush),
    .push      (push_ok),
    .push_data (push_rsp),
    .pop       (pop),
    .pop_data  (fifo_rsp),
    .full      (fifo_full),
    .empty     (fifo_empty)
  );

  assign bus.rsp_valid = !fifo_empty;
  assign bus.rsp_inst  = fifo_rsp.inst;
  assign bus.rsp_err   = fifo_rsp.err;
  assign pop           = !fifo_empty && bus.rsp_ready;

  // One credit per response slot; outstanding requests never exceed buffer capacity.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      credits <= CREDIT_MAX;
    end else if (bus.flush) begin
      credits <= CREDIT_MAX;
    end else begin
      case ({accept, pop})
        2'b10:   credits <= credits - CNT_W'(1);
        2'b01:   credits <= credits + CNT_W'(1);
        default: credits <= credits;
      endcase
    end
  end

  assign bus.busy = (credits != CREDIT_MAX);

endmodule

// File: tb/tb_imem_responder.sv
// Directed bench for imem_responder with an in-order response scoreboard.
module tb_imem_responder;
  import imem_pkg::*;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  imem_if bus ();

  imem_responder dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  int checks = 0;
  int errors = 0;
  int cyc_n  = 0;
  int acc_n  = 0;
  int c0, p0, a0;

  logic [32:0]       exp_q [$];
  int                pop_cyc [$];
  logic [D_SIZE-1:0] mdl [IMEM_DEPTH];
  logic [D_SIZE-1:0] last_inst;
  logic [32:0]       head;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [32:0] expect_rsp(input logic [31:0] a);
    if ((a[1:0] != 2'b00) || (a >= 32'(4 * IMEM_DEPTH))) return {1'b1, 32'h0};
    return {1'b0, mdl[int'(a >> 2)]};
  endfunction

  // One bench cycle: sample handshakes after inputs settle, update model, advance to next negedge.
  task automatic cyc();
    logic [32:0] e;
    #1;
    if (bus.load_en && (bus.load_addr[1:0] == 2'b00) && (bus.load_addr < 32'(4 * IMEM_DEPTH)))
      mdl[int'(bus.load_addr >> 2)] = bus.load_data;
    if (bus.req_valid && bus.req_ready) begin
      exp_q.push_back(expect_rsp(bus.req_addr));
      acc_n++;
    end
    if (bus.rsp_valid && bus.rsp_ready) begin
      pop_cyc.push_back(cyc_n);
      chk("rsp_pending", 64'(exp_q.size() != 0), 64'd1);
      if (exp_q.size() != 0) begin
        e = exp_q.pop_front();
        chk("rsp_inst", 64'(bus.rsp_inst), 64'(e[31:0]));
        chk("rsp_err", 64'(bus.rsp_err), 64'(e[32]));
        last_inst = bus.rsp_inst;
      end
    end
    if (bus.flush) exp_q.delete();
    @(negedge clk);
    cyc_n++;
  endtask

  task automatic wait_drain();
    for (int i = 0; i < 30 && (exp_q.size() != 0 || bus.rsp_valid); i++) cyc();
    chk("drain_empty", 64'(exp_q.size()), 64'd0);
  endtask

  task automatic req(input logic [31:0] a);
    bus.req_valid = 1'b1;
    bus.req_addr  = a;
    cyc();
    bus.req_valid = 1'b0;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog expired at cycle %0d", cyc_n);
    $fatal(1, "watchdog");
  end

  initial begin
    for (int i = 0; i < IMEM_DEPTH; i++) mdl[i] = '0;
    last_inst     = '0;
    reset         = 1'b0;
    bus.req_valid = 1'b0;
    bus.req_addr  = '0;
    bus.rsp_ready = 1'b0;
    bus.load_en   = 1'b0;
    bus.load_addr = '0;
    bus.load_data = '0;
    bus.flush     = 1'b0;
    repeat (2) @(negedge clk);
    #1;
    chk("rst_rsp_valid", 64'(bus.rsp_valid), 64'd0);
    chk("rst_rsp_inst", 64'(bus.rsp_inst), 64'd0);
    chk("rst_rsp_err", 64'(bus.rsp_err), 64'd0);
    chk("rst_busy", 64'(bus.busy), 64'd0);
    @(negedge clk);
    reset = 1'b1;
    cyc();
    chk("post_rst_ready", 64'(bus.req_ready), 64'd1);
    chk("post_rst_busy", 64'(bus.busy), 64'd0);

    // Program load of the first four words
    for (int k = 0; k < 4; k++) begin
      bus.load_en   = 1'b1;
      bus.load_addr = 32'(4 * k);
      bus.load_data = 32'(17 * (k + 1));
      cyc();
    end
    bus.load_en = 1'b0;

    // Back-to-back fetches with the consumer always ready
    bus.rsp_ready = 1'b1;
    c0 = cyc_n;
    p0 = pop_cyc.size();
    for (int k = 0; k < 4; k++) req(32'(4 * k));
    wait_drain();
    chk("t1_count", 64'(pop_cyc.size() - p0), 64'd4);
    if (pop_cyc.size() >= p0 + 4) begin
      chk("t1_first_latency", 64'(pop_cyc[p0] - c0), 64'(IMEM_LATENCY));
      chk("t1_one_per_cycle", 64'(pop_cyc[p0+3] - pop_cyc[p0]), 64'd3);
    end
    chk("t1_last_inst", 64'(last_inst), 64'h44);

    // Misaligned and out-of-range requests, then a good one
    req(32'h2);
    req(32'h400);
    req(32'h0);
    wait_drain();
    chk("t2_recover_inst", 64'(last_inst), 64'h11);

    // Backpressure: only RSP_DEPTH requests may be outstanding
    bus.rsp_ready = 1'b0;
    a0 = acc_n;
    for (int k = 0; k < 8; k++) begin
      bus.req_valid = 1'b1;
      bus.req_addr  = 32'(4 * (k % 4));
      cyc();
    end
    bus.req_valid = 1'b0;
    chk("t3_accepted", 64'(acc_n - a0), 64'(IMEM_RSP_DEPTH));
    chk("t3_ready_low", 64'(bus.req_ready), 64'd0);
    chk("t3_busy", 64'(bus.busy), 64'd1);
    repeat (3) cyc();
    head = exp_q[0];
    chk("t3_hold_valid", 64'(bus.rsp_valid), 64'd1);
    chk("t3_hold_inst", 64'(bus.rsp_inst), 64'(head[31:0]));
    bus.rsp_ready = 1'b1;
    p0 = pop_cyc.size();
    wait_drain();
    chk("t3_drained", 64'(pop_cyc.size() - p0), 64'(IMEM_RSP_DEPTH));
    chk("t3_ready_back", 64'(bus.req_ready), 64'd1);
    chk("t3_busy_clear", 64'(bus.busy), 64'd0);

    // Load and fetch of the same word in one cycle returns the new word
    bus.load_en   = 1'b1;
    bus.load_addr = 32'h8;
    bus.load_data = 32'hDEAD;
    req(32'h8);
    bus.load_en = 1'b0;
    wait_drain();
    chk("t4_write_first", 64'(last_inst), 64'hDEAD);

    // Flush with three requests in flight; a load during flush still lands
    bus.rsp_ready = 1'b0;
    req(32'h0);
    req(32'h4);
    req(32'hC);
    bus.flush     = 1'b1;
    bus.req_valid = 1'b1;
    bus.req_addr  = 32'h4;
    bus.load_en   = 1'b1;
    bus.load_addr = 32'h10;
    bus.load_data = 32'h55;
    #1;
    chk("t5_ready_in_flush", 64'(bus.req_ready), 64'd0);
    cyc();
    bus.flush     = 1'b0;
    bus.req_valid = 1'b0;
    bus.load_en   = 1'b0;
    chk("t5_rsp_valid", 64'(bus.rsp_valid), 64'd0);
    chk("t5_busy", 64'(bus.busy), 64'd0);
    bus.rsp_ready = 1'b1;
    repeat (3) cyc();
    c0 = cyc_n;
    p0 = pop_cyc.size();
    req(32'hC);
    wait_drain();
    chk("t5_count", 64'(pop_cyc.size() - p0), 64'd1);
    if (pop_cyc.size() > p0) chk("t5_latency", 64'(pop_cyc[p0] - c0), 64'(IMEM_LATENCY));
    chk("t5_inst", 64'(last_inst), 64'h44);
    req(32'h10);
    wait_drain();
    chk("t5_flush_load", 64'(last_inst), 64'h55);

    // Reset with two responses buffered
    bus.rsp_ready = 1'b0;
    req(32'h0);
    req(32'h4);
    repeat (3) cyc();
    chk("t6_buffered", 64'(bus.rsp_valid), 64'd1);
    reset = 1'b0;
    #1;
    chk("t6_valid_drop", 64'(bus.rsp_valid), 64'd0);
    chk("t6_busy_rst", 64'(bus.busy), 64'd0);
    exp_q.delete();
    cyc();
    reset = 1'b1;
    cyc();
    chk("t6_busy", 64'(bus.busy), 64'd0);
    chk("t6_ready", 64'(bus.req_ready), 64'd1);
    bus.rsp_ready = 1'b1;
    p0 = pop_cyc.size();
    repeat (5) cyc();
    chk("t6_no_rsp", 64'(pop_cyc.size() - p0), 64'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
